tmds_encoder_multi: RTL and testbench

Parametrised multi-channel TMDS/HDMI encoder that replaces the single-channel encoder in the video output path. Each cycle it encodes NUM_CHANNELS lanes of one pixel clock into 10-bit symbols, selecting control, video guard band, 8b/10b video, and, optionally, data-island guard band and TERC4. The datapath is a fixed two-stage pipeline with per-channel running disparity. Its output feeds the 10:1 serialisers.

---
 rtl/tmds_encoder_multi.sv | 182 ++++++++++++++++++
 tb/tb_tmds_encoder_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: two-stage pipeline producing control, guard, 8b/10b video and TERC4 symbols.
// Define TMDS_TERC4_EN to enable data-island (ISLAND_GUARD / ISLAND) encoding; otherwise those modes emit CONTROL.
module tmds_encoder_multi #(
  parameter int NUM_CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                mode,
  input  logic [8*NUM_CHANNELS-1:0] data,
  input  logic [2*NUM_CHANNELS-1:0] ctrl,
  input  logic [4*NUM_CHANNELS-1:0] terc4,
  output logic [10*NUM_CHANNELS-1:0] tmds
);

  localparam logic [2:0] MODE_CONTROL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd1;
  localparam logic [2:0] MODE_VIDEO        = 3'd2;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd3;
  localparam logic [2:0] MODE_ISLAND       = 3'd4;

  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] GUARD_A  = 10'b1011001100;
  localparam logic [9:0] GUARD_B  = 10'b0100110011;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_symbol(input logic [3:0] t);
    logic [9:0] s;
    case (t)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'ha: s = 10'b0110011100;
      4'hb: s = 10'b1011000110;
      4'hc: s = 10'b1010001110;
      4'hd: s = 10'b1001110001;
      4'he: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [4*NUM_CHANNELS-1:0] terc4_q, terc4_d;
`else
  logic unused_terc4;
  assign unused_terc4 = ^terc4;
`endif

  logic [2:0]                mode_q, mode_d;
  logic [2*NUM_CHANNELS-1:0] ctrl_q, ctrl_d;
  logic [8:0]                q_m_q [NUM_CHANNELS];
  logic [8:0]                q_m_d [NUM_CHANNELS];
  logic [3:0]                n1q_q [NUM_CHANNELS];
  logic [3:0]                n1q_d [NUM_CHANNELS];
  logic [5:0]                cnt_q [NUM_CHANNELS];
  logic [5:0]                cnt_d [NUM_CHANNELS];
  logic [10*NUM_CHANNELS-1:0] tmds_q, tmds_d;

  always_comb begin
    logic [7:0] d_byte;
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    d_byte   = '0;
    n1       = '0;
    use_xnor = 1'b0;
    qm       = '0;
    mode_d   = mode;
    ctrl_d   = ctrl;
`ifdef TMDS_TERC4_EN
    terc4_d  = terc4;
`endif
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      d_byte   = data[8*i +: 8];
      n1       = ones8(d_byte);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d_byte[0]);
      qm[0]    = d_byte[0];
      for (int k = 1; k < 8; k++) qm[k] = d_byte[k] ^ qm[k-1] ^ use_xnor;
      qm[8]    = ~use_xnor;
      q_m_d[i] = qm;
      n1q_d[i] = ones8(qm[7:0]);
    end
  end

  // Disparity arithmetic wraps modulo 64; only the sign tests need two's-complement care.
  always_comb begin
    logic [8:0] qm;
    logic [5:0] n1, n0, cnt, cnt_next;
    logic       cnt_pos, cnt_neg;
    logic [9:0] sym;
    qm = '0; n1 = '0; n0 = '0; cnt = '0; cnt_next = '0;
    cnt_pos = 1'b0; cnt_neg = 1'b0; sym = CTRL_00;
    tmds_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      qm       = q_m_q[i];
      n1       = {2'b00, n1q_q[i]};
      n0       = 6'd8 - n1;
      cnt      = cnt_q[i];
      cnt_pos  = !cnt[5] && (cnt != 6'd0);
      cnt_neg  = cnt[5];
      cnt_next = '0;
      sym      = ctrl_symbol(ctrl_q[2*i +: 2]);
      case (mode_q)
        MODE_VIDEO: begin
          if ((cnt == 6'd0) || (n1q_q[i] == 4'd4)) begin
            sym      = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_next = qm[8] ? (cnt + n1 - n0) : (cnt + n0 - n1);
          end else if ((cnt_pos && (n1q_q[i] > 4'd4)) || (cnt_neg && (n1q_q[i] < 4'd4))) begin
            sym      = {1'b1, qm[8], ~qm[7:0]};
            cnt_next = cnt + {4'b0000, qm[8], 1'b0} + n0 - n1;
          end else begin
            sym      = {1'b0, qm[8], qm[7:0]};
            cnt_next = cnt + n1 - n0 - {4'b0000, ~qm[8], 1'b0};
          end
        end
        MODE_VIDEO_GUARD: sym = ((i % 3) == 1) ? GUARD_B : GUARD_A;
`ifdef TMDS_TERC4_EN
        MODE_ISLAND_GUARD: sym = ((i % 3) == 0) ? terc4_symbol({2'b11, ctrl_q[2*i +: 2]}) : GUARD_B;
        MODE_ISLAND:       sym = terc4_symbol(terc4_q[4*i +: 4]);
`endif
        default: ;
      endcase
      tmds_d[10*i +: 10] = sym;
      cnt_d[i]           = cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_CONTROL;
      ctrl_q <= '0;
`ifdef TMDS_TERC4_EN
      terc4_q <= '0;
`endif
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        q_m_q[i] <= '0;
        n1q_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      tmds_q <= {NUM_CHANNELS{CTRL_00}};
    end else begin
      mode_q <= mode_d;
      ctrl_q <= ctrl_d;
`ifdef TMDS_TERC4_EN
      terc4_q <= terc4_d;
`endif
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        q_m_q[i] <= q_m_d[i];
        n1q_q[i] <= n1q_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tmds_q <= tmds_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Testbench for tmds_encoder_multi: directed literal checks plus a per-cycle comparison against a behavioural model.
module tb_tmds_encoder_multi;

  localparam int NCH = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           mode;
  logic [8*NCH-1:0]     data;
  logic [2*NCH-1:0]     ctrl;
  logic [4*NCH-1:0]     terc4;
  logic [10*NCH-1:0]    tmds;

  int checks   = 0;
  int failures = 0;

  tmds_encoder_multi #(.NUM_CHANNELS(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .data  (data),
    .ctrl  (ctrl),
    .terc4 (terc4),
    .tmds  (tmds)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GA  = 10'b1011001100;
  localparam logic [9:0] GB  = 10'b0100110011;

  logic [9:0] ctrl_tab [4]   = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc4_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // Each emitted video word shifts disparity by (ones - zeros) of the whole 10-bit word.
  function automatic logic [9:0] model_lane(input int lane, input logic [2:0] md, input logic [7:0] d,
                                            input logic [1:0] c, input logic [3:0] t,
                                            input int cnt_in, output int cnt_out);
    logic [9:0] w;
    logic [8:0] q;
    int ones, n1;
    bit x, inv;
    cnt_out = 0;
    w = ctrl_tab[c];
    if (md == 3'd2) begin
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(d[k]);
      x = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int k = 1; k < 8; k++) q[k] = d[k] ^ q[k-1] ^ x;
      q[8] = !x;
      n1 = 0;
      for (int k = 0; k < 8; k++) n1 += int'(q[k]);
      if (cnt_in == 0 || n1 == 4) inv = !q[8];
      else inv = (cnt_in > 0 && n1 > 4) || (cnt_in < 0 && n1 < 4);
      w = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
      cnt_out = cnt_in + 2 * $countones(w) - 10;
    end else if (md == 3'd1) begin
      w = (lane % 3 == 1) ? GB : GA;
`ifdef TMDS_TERC4_EN
    end else if (md == 3'd3) begin
      w = (lane % 3 == 0) ? terc4_tab[{2'b11, c}] : GB;
    end else if (md == 3'd4) begin
      w = terc4_tab[t];
`endif
    end
    return w;
  endfunction

  logic [10*NCH-1:0] exp_mid, exp_out;
  int  model_cnt [NCH];
  bit  model_valid = 1'b0;
  int  cycle = 0;

  always @(posedge clk) begin
    logic [10*NCH-1:0] nxt;
    int c_new;
    nxt = '0;
    cycle <= cycle + 1;
    if (reset) begin
      exp_out     <= {NCH{C00}};
      exp_mid     <= {NCH{C00}};
      model_valid <= 1'b1;
      for (int i = 0; i < NCH; i++) model_cnt[i] <= 0;
    end else begin
      exp_out <= exp_mid;
      for (int i = 0; i < NCH; i++) begin
        nxt[10*i +: 10] = model_lane(i, mode, data[8*i +: 8], ctrl[2*i +: 2], terc4[4*i +: 4],
                                     model_cnt[i], c_new);
        model_cnt[i] <= c_new;
      end
      exp_mid <= nxt;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (tmds !== exp_out) begin
        failures++;
        $display("[TB] FAIL model_cycle%0d got=%b exp=%b", cycle, tmds, exp_out);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [2:0] md, input logic [8*NCH-1:0] dat,
                               input logic [2*NCH-1:0] ctl, input logic [4*NCH-1:0] t4);
    @(negedge clk);
    reset = rst;
    mode  = md;
    data  = dat;
    ctrl  = ctl;
    terc4 = t4;
  endtask

  task automatic checkOutput(input string name, input logic [10*NCH-1:0] expv);
    checks++;
    if (tmds !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%b exp=%b", name, tmds, expv);
    end
  endtask

  function automatic logic [8*NCH-1:0] rand_data();
    logic [8*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic logic [2*NCH-1:0] rand_ctrl();
    logic [2*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[2*i +: 2] = 2'($urandom_range(0, 3));
    return v;
  endfunction

  function automatic logic [4*NCH-1:0] rand_terc4();
    logic [4*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    logic [10*NCH-1:0] island_exp [4];
    logic [10*NCH-1:0] ig_exp;
    reset = 1'b1;
    mode  = 3'd0;
    data  = '0;
    ctrl  = '0;
    terc4 = '0;

    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), rand_data(), rand_ctrl(), rand_terc4());
      checkOutput("reset_hold", {NCH{C00}});
    end
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("reset_release0", {NCH{C00}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("reset_release1", {NCH{C00}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("reset_release2", {NCH{C00}});

    // Lane-0 byte 0x00 three times: disparity walks 0 -> -8 -> +2 -> -6.
    applyStimulus(1'b0, 3'd2, '0, '0, '0);
    applyStimulus(1'b0, 3'd2, '0, '0, '0);
    applyStimulus(1'b0, 3'd2, '0, '0, '0);
    checkOutput("video00_first", {NCH{10'b0100000000}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("video00_second", {NCH{10'b1111111111}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("video00_third", {NCH{10'b0100000000}});

    applyStimulus(1'b0, 3'd2, {NCH{8'hff}}, '0, '0);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    applyStimulus(1'b0, 3'd2, {NCH{8'hff}}, '0, '0);
    checkOutput("videoFF_first", {NCH{10'b1000000000}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("videoFF_ctrl_gap", {NCH{C00}});
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("videoFF_after_ctrl", {NCH{10'b1000000000}});

    applyStimulus(1'b0, 3'd1, rand_data(), '0, '0);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("video_guard", {GA, GB, GA});

`ifdef TMDS_TERC4_EN
    ig_exp = {GB, GB, 10'b1001110001};
    island_exp[0] = {NCH{10'b1010011100}};
    island_exp[1] = {NCH{10'b0100111100}};
    island_exp[2] = {NCH{10'b1011001100}};
    island_exp[3] = {NCH{10'b1011000011}};
`else
    ig_exp = {C00, C00, C01};
    for (int k = 0; k < 4; k++) island_exp[k] = {NCH{C11}};
`endif
    applyStimulus(1'b0, 3'd3, '0, 6'b000001, '0);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("island_guard", ig_exp);

    applyStimulus(1'b0, 3'd4, '0, '1, {NCH{4'b0000}});
    applyStimulus(1'b0, 3'd4, '0, '1, {NCH{4'b0111}});
    applyStimulus(1'b0, 3'd4, '0, '1, {NCH{4'b1000}});
    checkOutput("island_0000", island_exp[0]);
    applyStimulus(1'b0, 3'd4, '0, '1, {NCH{4'b1111}});
    checkOutput("island_0111", island_exp[1]);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("island_1000", island_exp[2]);
    applyStimulus(1'b0, 3'd0, '0, '0, '0);
    checkOutput("island_1111", island_exp[3]);

    for (int n = 0; n < 120; n++)
      applyStimulus(1'b0, (n % 2 == 0) ? 3'd2 : 3'd0, rand_data(), rand_ctrl(), rand_terc4());
    for (int n = 0; n < 150; n++)
      applyStimulus(1'b0, 3'd2, rand_data(), rand_ctrl(), rand_terc4());
    for (int n = 0; n < 150; n++)
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), rand_data(), rand_ctrl(), rand_terc4());

    // Reset in the middle of a video run must flush both stages and the disparity.
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 3'd2, rand_data(), rand_ctrl(), rand_terc4());
    for (int n = 0; n < 2; n++)  applyStimulus(1'b1, 3'd2, rand_data(), rand_ctrl(), rand_terc4());
    for (int n = 0; n < 30; n++) applyStimulus(1'b0, 3'd2, rand_data(), rand_ctrl(), rand_terc4());
    for (int n = 0; n < 3; n++)  applyStimulus(1'b0, 3'd0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
